tx_wqe_sched_wrr: RTL and testbench
===================================

// Module: tx_wqe_sched_wrr
// PURPOSE
//  Doorbell-driven, weighted round-robin WQE fetch scheduler for the TX path. Tracks per-QP SQ
//  producer/consumer indices and issues one WQE-fetch request (QPN, SQ index, byte address) per
//  handshake to the WQE fetch engine. Unlike the fixed-1 arbiter it replaces, it grants each QP up
//  to WEIGHT WQEs per turn and derives work from doorbells instead of a static active mask.
// PARAMETERS
//  MAX_QP          32   number of QPs (power of 2)
//  QP_PTR_WIDTH    5    log2(MAX_QP)
//  SQ_DEPTH        128  WQEs per SQ (power of 2)
//  SQ_PTR_WIDTH    7    log2(SQ_DEPTH); indices carry 1 extra wrap bit
//  WQE_BYTES       64   WQE size in bytes (power of 2)
//  AXI_ADDR_WIDTH  32   request address width
//  WEIGHT_WIDTH    4    per-QP quantum width
//  DEFAULT_WEIGHT  1    quantum loaded into every QP at reset
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 synchronous active-high reset
//  i_active        in   MAX_QP            QP enable mask; inactive QPs are never selected
//  i_sq_base       in   AXI_ADDR_WIDTH    SQ region base address
//  i_db_valid      in   1                 doorbell strobe
//  i_db_qpn        in   QP_PTR_WIDTH      doorbell QP
//  i_db_pi         in   SQ_PTR_WIDTH+1    new absolute producer index (incl. wrap bit)
//  o_db_err        out  1                 1-cycle pulse: doorbell rejected
//  i_wt_valid      in   1                 weight write strobe
//  i_wt_qpn        in   QP_PTR_WIDTH      QP whose weight is written
//  i_wt            in   WEIGHT_WIDTH      new quantum (0 treated as 1)
//  i_stall         in   1                 downstream WQE cache almost-full
//  o_req_valid     out  1                 fetch request valid
//  i_req_ready     in   1                 fetch engine accepts request
//  o_req_qpn       out  QP_PTR_WIDTH      request QP
//  o_req_idx       out  SQ_PTR_WIDTH      SQ slot fetched
//  o_req_addr      out  AXI_ADDR_WIDTH    i_sq_base + qpn*SQ_DEPTH*WQE_BYTES + idx*WQE_BYTES (mod 2^AW)
//  o_pending       out  MAX_QP            per-QP pi != ci
// BEHAVIOUR
//  - Reset: pi=ci=0 and weight=DEFAULT_WEIGHT for all QPs; state IDLE; last_served=MAX_QP-1 (QP0
//    wins first); all outputs 0. Reset mid-request drops the request with no handshake.
//  - Doorbell: accepted iff (i_db_pi - ci[qpn]) mod 2*SQ_DEPTH <= SQ_DEPTH; pi updated next cycle.
//    Otherwise pi unchanged and o_db_err pulses the following cycle. A doorbell and a handshake on
//    the same QP in one cycle both take effect (check uses pre-increment ci).
//  - Weight write takes effect at that QP's next grant; never alters a quantum in progress.
//  - FSM IDLE: eligible = pending & i_active. If nonzero, pick first eligible QP scanning
//    last_served+1 .. upward with wrap; latch cur, deficit=max(weight,1); go SERVE next cycle.
//  - FSM SERVE: when !o_req_valid, pending[cur], active[cur], deficit!=0 and !i_stall, register
//    o_req_* from ci[cur] and set o_req_valid. On o_req_valid & i_req_ready: ci[cur]++ (mod
//    2*SQ_DEPTH), deficit--. If deficit becomes 0, ci reaches pi, or cur went inactive:
//    clear o_req_valid, last_served=cur, go IDLE; else o_req_valid stays high with the next idx
//    when !i_stall (back-to-back, 1 req/cycle), else drops.
//  - o_req_valid, once high, holds with stable fields until i_req_ready; i_stall and i_active
//    changes only gate new requests. Deactivating cur with no request outstanding -> IDLE next cycle.
//  - Latency: doorbell on an idle block at cycle t -> o_req_valid at t+3.
//  - Index slot = ci[SQ_PTR_WIDTH-1:0]; wrap bit distinguishes full (SQ_DEPTH entries) from empty.
// TESTING
//  - Reset, db QP3 pi=4, weight 1, ready=1 -> 4 reqs QP3 idx 0..3, addr=base+3*8192+{0,64,128,192}.
//  - QP1 w=3, QP2 w=1, both pi=6 -> grant order 1,1,1,2,1,1,1,2,2,2,2,2.
//  - db QP0 pi=128 (full), then pi=129 with ci=0 -> second rejected, o_db_err 1 cycle, pi stays 128.
//  - i_stall high during SERVE with req held, ready=0 -> valid/fields stable until ready; no new req.
//  - ci=pi=255 on QP5, db pi=1 -> reqs idx 127 then 0; pending[5] clears.
//  - Deactivate cur mid-quantum -> outstanding req completes, scheduler moves to next active QP.

Source files
------------

// File: rtl/tx_wqe_sched_wrr.sv
// Doorbell-driven weighted round-robin WQE fetch scheduler: tracks per-QP SQ producer/consumer
// indices and grants each eligible QP up to its quantum of fetch requests per turn.
module tx_wqe_sched_wrr #(
  parameter int unsigned MAX_QP         = 32,
  parameter int unsigned QP_PTR_WIDTH   = 5,
  parameter int unsigned SQ_DEPTH       = 128,
  parameter int unsigned SQ_PTR_WIDTH   = 7,
  parameter int unsigned WQE_BYTES      = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned WEIGHT_WIDTH   = 4,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAX_QP-1:0]         i_active,
  input  logic [AXI_ADDR_WIDTH-1:0] i_sq_base,
  input  logic                      i_db_valid,
  input  logic [QP_PTR_WIDTH-1:0]   i_db_qpn,
  input  logic [SQ_PTR_WIDTH:0]     i_db_pi,
  output logic                      o_db_err,
  input  logic                      i_wt_valid,
  input  logic [QP_PTR_WIDTH-1:0]   i_wt_qpn,
  input  logic [WEIGHT_WIDTH-1:0]   i_wt,
  input  logic                      i_stall,
  output logic                      o_req_valid,
  input  logic                      i_req_ready,
  output logic [QP_PTR_WIDTH-1:0]   o_req_qpn,
  output logic [SQ_PTR_WIDTH-1:0]   o_req_idx,
  output logic [AXI_ADDR_WIDTH-1:0] o_req_addr,
  output logic [MAX_QP-1:0]         o_pending
);

  localparam int unsigned PW    = SQ_PTR_WIDTH + 1;
  localparam int unsigned WB_SH = $clog2(WQE_BYTES);

  typedef enum logic {IDLE, SERVE} state_e;

  logic [PW-1:0]             pi_q [MAX_QP];
  logic [PW-1:0]             ci_q [MAX_QP];
  logic [WEIGHT_WIDTH-1:0]   wt_q [MAX_QP];
  state_e                    state_q, state_d;
  logic [QP_PTR_WIDTH-1:0]   cur_q, cur_d, last_q, last_d;
  logic [WEIGHT_WIDTH-1:0]   def_q, def_d;
  logic                      vld_q, vld_d;
  logic [QP_PTR_WIDTH-1:0]   qpn_q, qpn_d;
  logic [SQ_PTR_WIDTH-1:0]   idx_q, idx_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      db_err_q;

  logic [MAX_QP-1:0]         pend, elig;
  logic                      found;
  logic [QP_PTR_WIDTH-1:0]   pick, cand;
  logic [PW-1:0]             cur_ci, cur_pi, ci_inc, db_diff;
  logic                      db_ok, ci_adv;

  // {qpn, slot} is qpn*SQ_DEPTH + slot because SQ_DEPTH is a power of two
  function automatic logic [AXI_ADDR_WIDTH-1:0] wqe_addr(
    input logic [AXI_ADDR_WIDTH-1:0] base,
    input logic [QP_PTR_WIDTH-1:0]   qpn,
    input logic [SQ_PTR_WIDTH-1:0]   slot
  );
    return base + (AXI_ADDR_WIDTH'({qpn, slot}) << WB_SH);
  endfunction

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < MAX_QP; i++) begin
      pend[i] = (pi_q[i] != ci_q[i]);
    end
  end

  assign elig = pend & i_active;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= MAX_QP; k++) begin
      cand = last_q + QP_PTR_WIDTH'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign cur_ci  = ci_q[cur_q];
  assign cur_pi  = pi_q[cur_q];
  assign ci_inc  = cur_ci + 1'b1;
  assign db_diff = i_db_pi - ci_q[i_db_qpn];
  assign db_ok   = (db_diff <= PW'(SQ_DEPTH));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    def_d   = def_q;
    vld_d   = vld_q;
    qpn_d   = qpn_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ci_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          cur_d   = pick;
          def_d   = (wt_q[pick] == '0) ? WEIGHT_WIDTH'(1) : wt_q[pick];
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (vld_q) begin
          if (i_req_ready) begin
            ci_adv = 1'b1;
            def_d  = def_q - 1'b1;
            if (def_q == WEIGHT_WIDTH'(1) || ci_inc == cur_pi || !i_active[cur_q]) begin
              vld_d   = 1'b0;
              last_d  = cur_q;
              state_d = IDLE;
            end else if (i_stall) begin
              vld_d = 1'b0;
            end else begin
              idx_d  = ci_inc[SQ_PTR_WIDTH-1:0];
              addr_d = wqe_addr(i_sq_base, cur_q, ci_inc[SQ_PTR_WIDTH-1:0]);
            end
          end
        end else if (!pend[cur_q] || !i_active[cur_q] || def_q == '0) begin
          last_d  = cur_q;
          state_d = IDLE;
        end else if (!i_stall) begin
          vld_d  = 1'b1;
          qpn_d  = cur_q;
          idx_d  = cur_ci[SQ_PTR_WIDTH-1:0];
          addr_d = wqe_addr(i_sq_base, cur_q, cur_ci[SQ_PTR_WIDTH-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_QP; i++) begin
        pi_q[i] <= '0;
        ci_q[i] <= '0;
        wt_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= QP_PTR_WIDTH'(MAX_QP - 1);
      def_q    <= '0;
      vld_q    <= 1'b0;
      qpn_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      db_err_q <= 1'b0;
    end else begin
      if (i_db_valid && db_ok) pi_q[i_db_qpn] <= i_db_pi;
      if (i_wt_valid)          wt_q[i_wt_qpn] <= i_wt;
      if (ci_adv)              ci_q[cur_q]    <= ci_inc;
      db_err_q <= i_db_valid && !db_ok;
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      def_q    <= def_d;
      vld_q    <= vld_d;
      qpn_q    <= qpn_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
    end
  end

  assign o_db_err    = db_err_q;
  assign o_req_valid = vld_q;
  assign o_req_qpn   = qpn_q;
  assign o_req_idx   = idx_q;
  assign o_req_addr  = addr_q;
  assign o_pending   = pend;

endmodule

// File: tb/tb_tx_wqe_sched_wrr.sv
// Scoreboard bench for tx_wqe_sched_wrr: directed doorbell/weight scenarios push expected
// requests; a negedge monitor pops and compares each handshake plus flagged per-cycle checks.
module tb_tx_wqe_sched_wrr;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_active = '1;
  logic [31:0] i_sq_base = BASE;
  logic        i_db_valid = 1'b0;
  logic [4:0]  i_db_qpn = '0;
  logic [7:0]  i_db_pi = '0;
  logic        o_db_err;
  logic        i_wt_valid = 1'b0;
  logic [4:0]  i_wt_qpn = '0;
  logic [3:0]  i_wt = '0;
  logic        i_stall = 1'b0;
  logic        o_req_valid;
  logic        i_req_ready = 1'b1;
  logic [4:0]  o_req_qpn;
  logic [6:0]  o_req_idx;
  logic [31:0] o_req_addr;
  logic [31:0] o_pending;

  tx_wqe_sched_wrr #(
    .MAX_QP(32), .QP_PTR_WIDTH(5), .SQ_DEPTH(128), .SQ_PTR_WIDTH(7),
    .WQE_BYTES(64), .AXI_ADDR_WIDTH(32), .WEIGHT_WIDTH(4), .DEFAULT_WEIGHT(1)
  ) dut (
    .clk(clk), .rst(rst), .i_active(i_active), .i_sq_base(i_sq_base),
    .i_db_valid(i_db_valid), .i_db_qpn(i_db_qpn), .i_db_pi(i_db_pi), .o_db_err(o_db_err),
    .i_wt_valid(i_wt_valid), .i_wt_qpn(i_wt_qpn), .i_wt(i_wt), .i_stall(i_stall),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_qpn(o_req_qpn),
    .o_req_idx(o_req_idx), .o_req_addr(o_req_addr), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] qpn;
    logic [6:0] idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  bit         chk_valid = 0, exp_valid = 0;
  bit         chk_hold = 0, chk_err = 0, exp_err = 0;
  bit         chk_pend = 0, exp_pend = 0, chk_rst = 0, tmo = 0, done = 0;
  logic [4:0] hold_qpn = '0;
  logic [6:0] hold_idx = '0;
  int         pend_bit = 0;

  function automatic logic [31:0] exp_addr(input logic [4:0] q, input logic [6:0] i);
    return BASE + 32'(q) * 32'd8192 + 32'(i) * 32'd64;
  endfunction

  // Monitor: sole owner of the error/check counters
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL sb_leftover got %0d outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (o_req_valid && i_req_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req got qpn=%0d idx=%0d, expected no request", o_req_qpn, o_req_idx);
        end else begin
          e = sb.pop_front();
          if (o_req_qpn !== e.qpn || o_req_idx !== e.idx || o_req_addr !== exp_addr(e.qpn, e.idx)) begin
            errors++;
            $display("FAIL req got qpn=%0d idx=%0d addr=%h, expected qpn=%0d idx=%0d addr=%h",
                     o_req_qpn, o_req_idx, o_req_addr, e.qpn, e.idx, exp_addr(e.qpn, e.idx));
          end
        end
      end
      if (chk_valid) begin
        checks++;
        if (o_req_valid !== exp_valid) begin
          errors++;
          $display("FAIL req_valid got %b, expected %b", o_req_valid, exp_valid);
        end
      end
      if (chk_hold) begin
        checks++;
        if (o_req_valid !== 1'b1 || o_req_qpn !== hold_qpn || o_req_idx !== hold_idx ||
            o_req_addr !== exp_addr(hold_qpn, hold_idx)) begin
          errors++;
          $display("FAIL hold got v=%b qpn=%0d idx=%0d addr=%h, expected v=1 qpn=%0d idx=%0d addr=%h",
                   o_req_valid, o_req_qpn, o_req_idx, o_req_addr, hold_qpn, hold_idx,
                   exp_addr(hold_qpn, hold_idx));
        end
      end
      if (chk_err) begin
        checks++;
        if (o_db_err !== exp_err) begin
          errors++;
          $display("FAIL db_err got %b, expected %b", o_db_err, exp_err);
        end
      end
      if (chk_pend) begin
        checks++;
        if (o_pending[pend_bit] !== exp_pend) begin
          errors++;
          $display("FAIL pending[%0d] got %b, expected %b", pend_bit, o_pending[pend_bit], exp_pend);
        end
      end
      if (chk_rst) begin
        checks++;
        if (o_req_valid !== 1'b0 || o_req_qpn !== '0 || o_req_idx !== '0 || o_req_addr !== '0 ||
            o_db_err !== 1'b0 || o_pending !== '0) begin
          errors++;
          $display("FAIL reset_state got v=%b qpn=%0d idx=%0d addr=%h err=%b pend=%h, expected all 0",
                   o_req_valid, o_req_qpn, o_req_idx, o_req_addr, o_db_err, o_pending);
        end
      end
      if (tmo) begin
        checks++;
        errors++;
        $display("FAIL timeout got %0d requests still outstanding, expected 0", sb.size());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_valid = 0; chk_hold = 0; chk_err = 0; chk_pend = 0; chk_rst = 0; tmo = 0;
    i_db_valid = 0; i_wt_valid = 0;
  endtask

  task automatic db(input logic [4:0] q, input logic [7:0] pi);
    i_db_valid = 1; i_db_qpn = q; i_db_pi = pi;
    step();
  endtask

  task automatic wt(input logic [4:0] q, input logic [3:0] w);
    i_wt_valid = 1; i_wt_qpn = q; i_wt = w;
    step();
  endtask

  task automatic push(input logic [4:0] q, input logic [6:0] i);
    exp_t e;
    e.qpn = q; e.idx = i;
    sb.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      tmo = 1;
      step();
      sb.delete();
    end
    repeat (4) step();
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!o_req_valid && n < maxc) begin
      step();
      n++;
    end
    if (!o_req_valid) begin
      tmo = 1;
      step();
    end
  endtask

  task automatic expect_pend(input int b, input bit v);
    chk_pend = 1; pend_bit = b; exp_pend = v;
    step();
  endtask

  initial begin
    repeat (3) step();
    chk_rst = 1;
    step();
    rst = 0;
    step();

    // Single QP, weight 1, plus doorbell-to-request latency
    for (int i = 0; i < 4; i++) push(5'd3, 7'(i));
    db(5'd3, 8'd4);
    chk_valid = 1; exp_valid = 0;
    step();
    chk_valid = 1; exp_valid = 0;
    step();
    chk_valid = 1; exp_valid = 1;
    step();
    drain(200);

    // Weighted interleave QP1 (w=3) vs QP2 (w=1)
    wt(5'd1, 4'd3);
    wt(5'd2, 4'd1);
    for (int i = 0; i < 3; i++) push(5'd1, 7'(i));
    push(5'd2, 7'd0);
    for (int i = 3; i < 6; i++) push(5'd1, 7'(i));
    for (int i = 1; i < 6; i++) push(5'd2, 7'(i));
    db(5'd1, 8'd6);
    db(5'd2, 8'd6);
    drain(300);

    // Full SQ accepted, over-full rejected
    i_active[0] = 1'b0;
    wt(5'd0, 4'd15);
    db(5'd0, 8'd128);
    chk_err = 1; exp_err = 0;
    db(5'd0, 8'd129);
    chk_err = 1; exp_err = 1;
    step();
    chk_err = 1; exp_err = 0;
    expect_pend(0, 1'b1);
    for (int i = 0; i < 128; i++) push(5'd0, 7'(i));
    i_active[0] = 1'b1;
    drain(2000);
    expect_pend(0, 1'b0);

    // Wrap-bit crossing on QP5: ci/pi reach 255, then pi=1
    wt(5'd5, 4'd15);
    for (int i = 0; i < 128; i++) push(5'd5, 7'(i));
    db(5'd5, 8'd128);
    drain(2000);
    for (int i = 0; i < 127; i++) push(5'd5, 7'(i));
    db(5'd5, 8'd255);
    drain(2000);
    push(5'd5, 7'd127);
    push(5'd5, 7'd0);
    db(5'd5, 8'd1);
    drain(100);
    expect_pend(5, 1'b0);

    // Stall while a request is held: fields stable, no new request after handshake
    wt(5'd6, 4'd2);
    i_req_ready = 0;
    push(5'd6, 7'd0);
    push(5'd6, 7'd1);
    db(5'd6, 8'd2);
    wait_valid(20);
    i_stall = 1;
    repeat (4) begin
      chk_hold = 1; hold_qpn = 5'd6; hold_idx = 7'd0;
      step();
    end
    i_req_ready = 1;
    step();
    repeat (3) begin
      chk_valid = 1; exp_valid = 0;
      step();
    end
    i_stall = 0;
    drain(50);

    // Deactivate current QP mid-quantum
    i_req_ready = 0;
    wt(5'd7, 4'd4);
    push(5'd7, 7'd0);
    push(5'd8, 7'd0);
    push(5'd8, 7'd1);
    db(5'd7, 8'd4);
    db(5'd8, 8'd2);
    wait_valid(20);
    i_active[7] = 1'b0;
    i_req_ready = 1;
    drain(100);
    expect_pend(7, 1'b1);
    for (int i = 1; i < 4; i++) push(5'd7, 7'(i));
    i_active[7] = 1'b1;
    drain(100);

    // Reset with a request outstanding drops it
    i_req_ready = 0;
    db(5'd9, 8'd1);
    wait_valid(20);
    rst = 1;
    step();
    chk_rst = 1;
    step();
    rst = 0;
    i_req_ready = 1;
    repeat (5) begin
      chk_valid = 1; exp_valid = 0;
      step();
    end

    done = 1;
    repeat (5) step();
  end
endmodule
